// File: rtl/layer_load_sched_if.sv
// Byte-stream input and layer-RAM write bus of the frame-load scheduler.
// The scheduler uses the slave modport; the stream source uses master.
interface layer_load_sched_if #(
    parameter int LAYERS = 8
);
    logic              frame_start_in;
    logic              byte_valid_in;
    logic [7:0]        byte_data_in;
    logic [LAYERS-1:0] wr_en_out;
    logic [5:0]        wr_addr_out;
    logic [7:0]        wr_data_out;
    logic [3:0]        wr_byte_en_out;
    logic [LAYERS-1:0] wr_done_out;
    logic              busy_out;
    logic              frame_done_out;
    logic              overflow_err_out;

    modport slave (
        input  frame_start_in, byte_valid_in, byte_data_in,
        output wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out,
        output wr_done_out, busy_out, frame_done_out, overflow_err_out
    );

    modport master (
        output frame_start_in, byte_valid_in, byte_data_in,
        input  wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out,
        input  wr_done_out, busy_out, frame_done_out, overflow_err_out
    );
endinterface

// File: rtl/layer_load_sched.sv
// Frame-load scheduler: spreads a serial pixel-byte stream across LAYERS
// layer RAMs (64 x 32-bit words, MSB lane first) and flags each layer done.
module layer_load_sched #(
    parameter int LAYERS      = 8,
    parameter int LAYER_BYTES = 256
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    layer_load_sched_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] layer_cnt, layer_nxt;
    logic [7:0] byte_cnt, byte_nxt;
    logic [3:0] wr_layer;
    logic [7:0] wr_byte;
    logic       accept, last_byte, last_layer;
    logic       ovf_nxt;
    logic       last_q;

    // A frame_start in the same cycle as a byte makes that byte byte 0 of
    // layer 0, so the write position is taken from the restarted counters.
    always_comb begin
        accept     = bus.byte_valid_in && (bus.frame_start_in || state == LOAD);
        wr_layer   = bus.frame_start_in ? '0 : layer_cnt;
        wr_byte    = bus.frame_start_in ? '0 : byte_cnt;
        last_byte  = (wr_byte == 8'(LAYER_BYTES - 1));
        last_layer = (wr_layer == 4'(LAYERS - 1));

        state_nxt = state;
        layer_nxt = wr_layer;
        byte_nxt  = wr_byte;

        if (bus.frame_start_in)
            state_nxt = LOAD;
        else if (state == DONE)
            state_nxt = IDLE;

        if (accept) begin
            if (last_byte) begin
                byte_nxt  = '0;
                layer_nxt = last_layer ? '0 : wr_layer + 4'd1;
                if (last_layer)
                    state_nxt = DONE;
            end else begin
                byte_nxt = wr_byte + 8'd1;
            end
        end

        ovf_nxt = bus.overflow_err_out;
        if (bus.frame_start_in)
            ovf_nxt = 1'b0;
        else if (bus.byte_valid_in && !accept)
            ovf_nxt = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            layer_cnt <= '0;
            byte_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            layer_cnt <= layer_nxt;
            byte_cnt  <= byte_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.wr_en_out        <= '0;
            bus.wr_addr_out      <= '0;
            bus.wr_data_out      <= '0;
            bus.wr_byte_en_out   <= '0;
            bus.wr_done_out      <= '0;
            bus.frame_done_out   <= 1'b0;
            bus.overflow_err_out <= 1'b0;
            last_q               <= 1'b0;
        end else begin
            bus.wr_en_out        <= accept ? (LAYERS'(1) << wr_layer) : '0;
            if (accept) begin
                bus.wr_addr_out    <= wr_byte[7:2];
                bus.wr_data_out    <= bus.byte_data_in;
                bus.wr_byte_en_out <= 4'b1000 >> wr_byte[1:0];
            end
            last_q               <= accept && last_byte;
            bus.wr_done_out      <= last_q ? bus.wr_en_out : '0;
            bus.frame_done_out   <= last_q && bus.wr_en_out[LAYERS-1];
            bus.overflow_err_out <= ovf_nxt;
        end
    end

    assign bus.busy_out = (state == LOAD);
endmodule

// File: tb/tb_layer_load_sched.sv
// Scoreboard bench for layer_load_sched: stimulus pushes expected writes and
// done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_layer_load_sched;
    localparam int LAYERS = 8;
    localparam int LB     = 256;

    typedef struct {
        logic [LAYERS-1:0] en;
        logic [5:0]        addr;
        logic [7:0]        data;
        logic [3:0]        ben;
        int                cyc;
    } wr_t;

    typedef struct {
        logic [LAYERS-1:0] done;
        logic              fdone;
        int                cyc;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    wr_t   wq[$];
    done_t dq[$];

    // model state: 0 idle, 1 load, 2 done
    int m_st = 0, m_layer = 0, m_byte = 0;

    layer_load_sched_if #(.LAYERS(LAYERS)) bus ();

    layer_load_sched #(.LAYERS(LAYERS), .LAYER_BYTES(LB)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en_out != '0) begin
                if (wq.size() == 0) begin
                    chk("write_not_expected", 32'(bus.wr_en_out), 32'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_en", 32'(bus.wr_en_out), 32'(e.en));
                    chk("wr_addr", 32'(bus.wr_addr_out), 32'(e.addr));
                    chk("wr_data", 32'(bus.wr_data_out), 32'(e.data));
                    chk("wr_byte_en", 32'(bus.wr_byte_en_out), 32'(e.ben));
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.wr_done_out != '0 || bus.frame_done_out) begin
                if (dq.size() == 0) begin
                    chk("done_not_expected", 32'({bus.wr_done_out, bus.frame_done_out}), 32'd0);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("wr_done", 32'(bus.wr_done_out), 32'(d.done));
                    chk("frame_done", 32'(bus.frame_done_out), 32'(d.fdone));
                    chk("done_cycle", 32'(cyc), 32'(d.cyc));
                    if (d.fdone) chk("busy_at_frame_done", 32'(bus.busy_out), 32'd0);
                end
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit start, input bit valid, input logic [7:0] d);
        int st0;
        st0 = m_st;
        bus.frame_start_in = start;
        bus.byte_valid_in  = valid;
        bus.byte_data_in   = d;
        if (start) begin
            m_st = 1; m_layer = 0; m_byte = 0;
        end
        if (valid && (start || st0 == 1)) begin
            wr_t e;
            e.en   = LAYERS'(1) << m_layer;
            e.addr = 6'(m_byte / 4);
            e.data = d;
            e.ben  = 4'b1000 >> (m_byte % 4);
            e.cyc  = cyc + 1;
            wq.push_back(e);
            if (m_byte == LB - 1) begin
                done_t dd;
                dd.done  = LAYERS'(1) << m_layer;
                dd.fdone = (m_layer == LAYERS - 1);
                dd.cyc   = cyc + 2;
                dq.push_back(dd);
                if (m_layer == LAYERS - 1) begin
                    m_st = 2; m_layer = 0;
                end else begin
                    m_layer++;
                end
                m_byte = 0;
            end else begin
                m_byte++;
            end
        end
        if (!start && st0 == 2) m_st = 0;
        @(posedge clk);
        #1;
        bus.frame_start_in = 1'b0;
        bus.byte_valid_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({bus.wr_en_out, bus.wr_addr_out, bus.wr_byte_en_out, bus.busy_out,
                       bus.frame_done_out, bus.overflow_err_out}), 32'd0);
        chk({name, "_data_done"}, 32'({bus.wr_data_out, bus.wr_done_out}), 32'd0);
    endtask

    initial begin
        bus.frame_start_in = 1'b0;
        bus.byte_valid_in  = 1'b0;
        bus.byte_data_in   = 8'h00;
        #23;
        chk_all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full back-to-back frame
        step(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < LAYERS * LB; n++) begin
            step(1'b0, 1'b1, 8'(n));
            if (n == 2 * LB + 5) begin
                chk("l2b5_wr_en", 32'(bus.wr_en_out), 32'h04);
                chk("l2b5_addr", 32'(bus.wr_addr_out), 32'd1);
                chk("l2b5_byte_en", 32'(bus.wr_byte_en_out), 32'b0100);
                chk("l2b5_data", 32'(bus.wr_data_out), 32'h05);
                chk("busy_mid_frame", 32'(bus.busy_out), 32'd1);
            end
        end
        idle(3);
        chk("busy_after_frame", 32'(bus.busy_out), 32'd0);

        // overflow in idle, sticky, cleared by start+valid in same cycle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h5A);
        chk("overflow_set", 32'(bus.overflow_err_out), 32'd1);
        idle(2);
        chk("overflow_sticky", 32'(bus.overflow_err_out), 32'd1);
        step(1'b1, 1'b1, 8'hAA);
        chk("sim_wr_en", 32'(bus.wr_en_out), 32'h01);
        chk("sim_addr", 32'(bus.wr_addr_out), 32'd0);
        chk("sim_byte_en", 32'(bus.wr_byte_en_out), 32'b1000);
        chk("sim_data", 32'(bus.wr_data_out), 32'hAA);
        chk("sim_overflow_clr", 32'(bus.overflow_err_out), 32'd0);
        idle(2);

        // restart mid-layer: 300 bytes, then a fresh full frame
        step(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 300; n++) step(1'b0, 1'b1, 8'(n));
        step(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < LAYERS * LB; n++) begin
            step(1'b0, 1'b1, 8'(n + 7));
            if (n == 0) begin
                chk("restart_wr_en", 32'(bus.wr_en_out), 32'h01);
                chk("restart_addr", 32'(bus.wr_addr_out), 32'd0);
                chk("restart_byte_en", 32'(bus.wr_byte_en_out), 32'b1000);
            end
        end
        idle(3);

        // gapped stream
        step(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < LAYERS * LB; n++) begin
            idle(int'($urandom_range(0, 3)));
            step(1'b0, 1'b1, 8'(n));
        end
        idle(3);

        // asynchronous reset mid-frame, asserted off the clock edge
        step(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 100; n++) step(1'b0, 1'b1, 8'(n ^ 8'h3C));
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset_outputs");
        wq.delete();
        dq.delete();
        m_st = 0; m_layer = 0; m_byte = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        chk("post_reset_overflow", 32'(bus.overflow_err_out), 32'd1);
        chk("post_reset_busy", 32'(bus.busy_out), 32'd0);
        idle(4);

        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("done_queue_drained", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/layer_load_sched.md
Name: layer_load_sched

Overview:
- Frame-load scheduler sitting between the byte-stream receiver (SPI/host side) and the array of per-layer WS281x code engines.
- Takes a serial stream of pixel bytes and distributes it across LAYERS layer RAMs.
- Each layer is LAYER_BYTES bytes, stored as 64 x 32-bit words written one byte lane at a time.
- Generates each layer's write strobe, word address, byte-lane enable and write-done pulse, so every layer engine starts shifting as soon as its own data is complete.

Parameters:
- LAYERS, 8, number of layer engines/RAMs served; 1..16.
- LAYER_BYTES, 256, bytes per layer; multiple of 4, 4..256 (fits 6-bit word address x 4 lanes).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset
- frame_start_in  input  1  single-cycle pulse; start (or restart) a frame at layer 0, byte 0
- byte_valid_in  input  1  byte_data_in valid this cycle
- byte_data_in  input  8  pixel byte
- wr_en_out  output  LAYERS  one-hot write strobe to the selected layer RAM
- wr_addr_out  output  6  word address, shared by all layers
- wr_data_out  output  8  byte data, shared by all layers
- wr_byte_en_out  output  4  one-hot byte-lane enable
- wr_done_out  output  LAYERS  one-cycle pulse: layer fully written
- busy_out  output  1  frame load in progress
- frame_done_out  output  1  one-cycle pulse: all layers written
- overflow_err_out  output  1  sticky: byte received outside a frame

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n_in is asynchronous, active-low. While reset is asserted, every output is 0, the FSM is in IDLE and all counters are 0.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on frame_start_in.
- LOAD -> DONE when the last byte of layer LAYERS-1 is accepted.
- DONE -> IDLE after 1 cycle.
- DONE -> LOAD if frame_start_in is high that same cycle.
- busy_out = 1 in LOAD only.
- Counters: layer_cnt (0..LAYERS-1) and byte_cnt (0..LAYER_BYTES-1). Both clear on frame_start_in.
- Byte acceptance: in LOAD, each byte_valid_in cycle accepts one byte. byte_cnt increments and wraps to 0 at LAYER_BYTES-1; layer_cnt increments on that wrap.
- Write outputs, registered with 1-cycle latency from the accepting edge:
  - wr_en_out[layer_cnt] = 1 (only that bit)
  - wr_addr_out = byte_cnt[7:2]
  - wr_data_out = byte_data_in
  - wr_byte_en_out = 4'b1000 >> byte_cnt[1:0], so the first byte lands in bits 31:24 (MSB-first shift order)
- Between writes: wr_en_out = 0. wr_addr_out, wr_data_out and wr_byte_en_out hold their last values.
- wr_done_out[L]: pulses 1 cycle after the wr_en_out cycle that carries byte LAYER_BYTES-1 of layer L, i.e. 2 cycles after that byte's byte_valid_in.
- frame_done_out: pulses in the same cycle as wr_done_out[LAYERS-1].
- Valid bytes may arrive every cycle. There is no back-pressure.
- Boundary conditions:
  - byte_valid_in in IDLE or DONE: byte dropped, no write, overflow_err_out set to 1. It stays set until the next frame_start_in or reset.
  - frame_start_in during LOAD: abort and restart at layer 0, byte 0. No wr_done_out pulse for the partially written layer. Already-completed layers keep the wr_done_out they were given. Any write already in the output register still completes next cycle.
  - frame_start_in and byte_valid_in in the same cycle: frame_start takes priority, and that byte is accepted as byte 0 of layer 0 of the new frame. overflow_err_out is cleared, not set.
  - Last byte of a frame and frame_start_in in the same cycle: the last byte is not written. The restart applies and that byte becomes byte 0 of the new frame.
  - Reset mid-frame: all state is cleared immediately. Partially loaded layers get no wr_done_out.
  - LAYERS=1: wr_done_out[0] and frame_done_out are coincident.

Test Plan:
- Full frame, LAYERS=8, LAYER_BYTES=256:
  - Stimulus: frame_start, then 2048 back-to-back bytes with value n[7:0].
  - Required: wr_en_out one-hot for layers 0..7, 256 writes each.
  - Byte 5 of layer 2 -> wr_en_out=8'h04, addr=1, byte_en=4'b0100, data=0x05.
  - wr_done_out[L] is 2 cycles after byte 256*L+255.
  - frame_done_out pulses together with wr_done_out[7]; busy_out then drops.
- Gapped stream:
  - Stimulus: frame_start, then bytes with random 0..3 idle cycles between them.
  - Required: identical writes to the back-to-back case, each write 1 cycle after its valid; wr_en_out=0 in idle cycles.
- Overflow:
  - Stimulus: 3 bytes in IDLE.
  - Required: no wr_en_out, overflow_err_out=1 and sticky; the next frame_start clears it.
- Restart mid-layer:
  - Stimulus: frame_start, 300 bytes, frame_start, then 2048 bytes.
  - Required: exactly one wr_done_out[0] pulse from the first frame; the second frame starts at layer 0, addr 0, byte_en 4'b1000.
- Simultaneous start and valid:
  - Stimulus: frame_start and byte_valid with data 0xAA in the same cycle.
  - Required: next cycle wr_en_out[0]=1, addr 0, byte_en 4'b1000, data 0xAA; overflow_err_out=0.
- Async reset:
  - Stimulus: assert rst_n_in low mid-frame, off a clock edge.
  - Required: all outputs 0 immediately; after release, the FSM is in IDLE and bytes set overflow_err_out.
